// File: rtl/regdec_pkg.sv
// Shared constants for the register-file write decoder and busy scoreboard.
package regdec_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  function automatic int nreg_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regdec_scoreboard_decoder_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable; all zeros when disabled.
module decoder_onehot #(
  parameter int N = 5
) (
  input  logic              en,
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/regdec_scoreboard.sv
// Writeback one-hot enable decoder plus busy-register scoreboard for RAW/WAW stalls.
// Optional build macro REGDEC_X0_HARDWIRED_EN: register 0 is never busy and its writebacks are dropped.
module regdec_scoreboard
  import regdec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_sel,
  output logic [2**ADDR_W-1:0]    wr_onehot,
  output logic                    wr_valid,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_sel,
  output logic                    iss_ready,
  input  logic [ADDR_W-1:0]       rs1_sel,
  input  logic [ADDR_W-1:0]       rs2_sel,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    flush,
  output logic [2**ADDR_W-1:0]    busy,
  output logic [ADDR_W:0]         busy_cnt,
  output logic                    wr_err
);

  localparam int NREG = nreg_of(ADDR_W);
  localparam int CW   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] XZ = ADDR_W'(ZERO_REG);

`ifdef REGDEC_X0_HARDWIRED_EN
  localparam bit X0_HW = 1'b1;
`else
  localparam bit X0_HW = 1'b0;
`endif

  logic            wr_eff;
  logic            iss_acc;
  logic            iss_x0;
  logic            inc;
  logic            dec;
  logic [NREG-1:0] wr_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] busy_nxt;

  // Writeback to a hardwired x0 is dropped entirely: no enable, no clear, no error.
  assign wr_eff = wr_en && !(X0_HW && (wr_sel == XZ));
  assign iss_x0 = X0_HW && (iss_sel == XZ);

  // Same-cycle writeback to the issuing destination frees it in time for the new producer.
  assign iss_ready = flush || iss_x0 || !busy[iss_sel] || (wr_en && (wr_sel == iss_sel));
  assign iss_acc   = iss_en && iss_ready && !flush && !iss_x0;

  assign rs1_busy = busy[rs1_sel] && !(wr_en && (wr_sel == rs1_sel))
                    && !(X0_HW && (rs1_sel == XZ));
  assign rs2_busy = busy[rs2_sel] && !(wr_en && (wr_sel == rs2_sel))
                    && !(X0_HW && (rs2_sel == XZ));

  decoder_onehot #(.N(ADDR_W)) u_dec_wr (
    .en     (wr_eff),
    .sel    (wr_sel),
    .onehot (wr_mask)
  );

  decoder_onehot #(.N(ADDR_W)) u_dec_iss (
    .en     (iss_acc),
    .sel    (iss_sel),
    .onehot (set_mask)
  );

  // Set has priority over clear, so OR the set mask in after masking the clear.
  assign busy_nxt = (busy & ~wr_mask) | set_mask;

  // Count only real transitions: a clear of an idle register or a set+clear pair is net zero.
  assign inc = iss_acc && !busy[iss_sel];
  assign dec = wr_eff && busy[wr_sel] && !(iss_acc && (iss_sel == wr_sel));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_onehot <= '0;
      wr_valid  <= 1'b0;
      busy      <= '0;
      busy_cnt  <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_onehot <= wr_mask;
      wr_valid  <= wr_eff;
      if (flush) begin
        busy     <= '0;
        busy_cnt <= '0;
      end else begin
        busy     <= busy_nxt;
        busy_cnt <= busy_cnt + CW'(inc) - CW'(dec);
      end
      if (wr_eff && !busy[wr_sel] && !flush) wr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regdec_scoreboard.sv
// Directed bench for regdec_scoreboard at ADDR_W=5 with hand-computed expectations.
module tb_regdec_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_onehot;
  logic        wr_valid;
  logic        iss_en;
  logic [4:0]  iss_sel;
  logic        iss_ready;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        flush;
  logic [31:0] busy;
  logic [5:0]  busy_cnt;
  logic        wr_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regdec_scoreboard #(.ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_onehot (wr_onehot),
    .wr_valid  (wr_valid),
    .iss_en    (iss_en),
    .iss_sel   (iss_sel),
    .iss_ready (iss_ready),
    .rs1_sel   (rs1_sel),
    .rs2_sel   (rs2_sel),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .flush     (flush),
    .busy      (busy),
    .busy_cnt  (busy_cnt),
    .wr_err    (wr_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_sel = '0; iss_en = 1'b0; iss_sel = '0;
    rs1_sel = '0; rs2_sel = '0; flush = 1'b0;
  endtask

  logic [31:0] exp_oh;

  initial begin
    idle();
    #1;

    // reset while a writeback is requested
    rst = 1'b1; wr_en = 1'b1; wr_sel = 5'd3;
    step();
    idle();
    #1;
    chk("rst_onehot", wr_onehot, 0);
    chk("rst_valid",  wr_valid,  0);
    chk("rst_busy",   busy,      0);
    chk("rst_cnt",    busy_cnt,  0);
    chk("rst_err",    wr_err,    0);

    // hazard on register 7
    iss_en = 1'b1; iss_sel = 5'd7;
    #1;
    chk("hz_ready_free", iss_ready, 1);
    step();
    iss_en = 1'b0; rs1_sel = 5'd7; iss_sel = 5'd7;
    #1;
    chk("hz_rs1_busy", rs1_busy, 1);
    chk("hz_ready_stall", iss_ready, 0);
    chk("hz_busy", busy, 32'h0000_0080);
    chk("hz_cnt", busy_cnt, 1);
    wr_en = 1'b1; wr_sel = 5'd7;
    #1;
    chk("hz_rs1_bypass", rs1_busy, 0);
    chk("hz_ready_bypass", iss_ready, 1);
    step();
    idle();
    #1;
    chk("hz_wr_onehot", wr_onehot, 32'h0000_0080);
    chk("hz_wr_valid", wr_valid, 1);
    chk("hz_busy_clr", busy, 0);
    chk("hz_cnt_clr", busy_cnt, 0);

    // simultaneous set and clear on register 5
    iss_en = 1'b1; iss_sel = 5'd5;
    step();
    #1;
    chk("sc_busy_set", busy, 32'h0000_0020);
    chk("sc_cnt_set", busy_cnt, 1);
    wr_en = 1'b1; wr_sel = 5'd5;
    step();
    #1;
    chk("sc_busy_keep", busy, 32'h0000_0020);
    chk("sc_cnt_keep", busy_cnt, 1);
    // back-to-back issue/writeback pairs keep the register owned
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_busy", busy, 32'h0000_0020);
      chk("b2b_cnt", busy_cnt, 1);
    end
    idle();
    wr_en = 1'b1; wr_sel = 5'd5;
    step();
    idle();
    #1;
    chk("sc_busy_clr", busy, 0);
    chk("sc_cnt_clr", busy_cnt, 0);

    // fill {2,9,31}, then flush with a concurrent issue
    iss_en = 1'b1; iss_sel = 5'd2;  step();
    iss_sel = 5'd9;                 step();
    iss_sel = 5'd31;                step();
    idle();
    rs2_sel = 5'd31; rs1_sel = 5'd4;
    #1;
    chk("fl_busy_fill", busy, 32'h8000_0204);
    chk("fl_cnt_fill", busy_cnt, 3);
    chk("fl_rs2_msb", rs2_busy, 1);
    chk("fl_rs1_idle", rs1_busy, 0);
    iss_sel = 5'd31;
    #1;
    chk("fl_ready_stall", iss_ready, 0);
    flush = 1'b1; iss_en = 1'b1; iss_sel = 5'd4;
    #1;
    chk("fl_ready_forced", iss_ready, 1);
    step();
    idle();
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_cnt", busy_cnt, 0);
    // flush suppresses the error but still decodes the writeback
    flush = 1'b1; wr_en = 1'b1; wr_sel = 5'd20;
    step();
    idle();
    #1;
    chk("fl_wr_onehot", wr_onehot, 32'h0010_0000);
    chk("fl_err_masked", wr_err, 0);

    // writeback to idle register 12 raises the sticky error
    wr_en = 1'b1; wr_sel = 5'd12;
    step();
    idle();
    #1;
    chk("err_set", wr_err, 1);
    iss_en = 1'b1; iss_sel = 5'd12; step();
    idle(); wr_en = 1'b1; wr_sel = 5'd12; step();
    idle();
    #1;
    chk("err_sticky", wr_err, 1);
    chk("err_cnt", busy_cnt, 0);

    // decode sweep over every address
    for (int s = 0; s < 32; s++) begin
      wr_en = 1'b1; wr_sel = 5'(s);
      step();
      exp_oh = 32'd1 << s;
`ifdef REGDEC_X0_HARDWIRED_EN
      if (s == 0) exp_oh = '0;
`endif
      chk("sweep_onehot", wr_onehot, exp_oh);
      chk("sweep_valid", wr_valid, (exp_oh != 0) ? 1 : 0);
    end
    idle();
    step();
    chk("sweep_off_onehot", wr_onehot, 0);
    chk("sweep_off_valid", wr_valid, 0);
    chk("sweep_err", wr_err, 1);

    // mid-operation reset drops pending state
    iss_en = 1'b1; iss_sel = 5'd3;
    step();
    #1;
    chk("mr_busy_pre", busy, 32'h0000_0008);
    rst = 1'b1; iss_en = 1'b1; iss_sel = 5'd6;
    step();
    idle();
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_cnt", busy_cnt, 0);
    chk("mr_err", wr_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regdec_scoreboard.md
# regdec_scoreboard

Parametrised register-file write-select decoder with a busy-register scoreboard for the RISC-V datapath. It converts a writeback address into a registered one-hot write-enable vector for the register file. It also tracks which destination registers have an in-flight write, so issue can stall on RAW and WAW hazards. It generalises the fixed 5-to-32 enable decoder to any address width and adds sequential hazard state.

## Interface
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers (derived, not overridable)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  writeback request this cycle
- wr_sel  in  ADDR_W  writeback destination register
- wr_onehot  out  NREG  registered one-hot register-file write enable
- wr_valid  out  1  registered; high when wr_onehot has a bit set
- iss_en  in  1  issue request; marks iss_sel busy when accepted
- iss_sel  in  ADDR_W  issuing instruction's destination register
- iss_ready  out  1  combinational; issue accepted when iss_en && iss_ready
- rs1_sel, rs2_sel  in  ADDR_W  source registers of the issuing instruction
- rs1_busy, rs2_busy  out  1  combinational; the source register has a pending write
- flush  in  1  clears all pending-write state (pipeline squash)
- busy  out  NREG  registered busy vector
- busy_cnt  out  ADDR_W+1  registered population count of busy
- wr_err  out  1  sticky; set by a writeback to a register that is not busy

## Operation
- Decode: on each cycle with wr_en=1, the next wr_onehot = 1 << wr_sel and wr_valid = 1. Otherwise wr_onehot = 0 and wr_valid = 0.
- Busy update, in priority order, evaluated per bit:
  - flush: all bits become 0. Issue is ignored. The writeback decode still occurs.
  - set: an accepted issue sets busy[iss_sel].
  - clear: wr_en clears busy[wr_sel].
- Set wins over clear on the same register in the same cycle. Net result: the register stays busy, owned by the new producer.
- iss_ready is high when either of these holds:
  - busy[iss_sel] = 0, or
  - wr_en=1 and wr_sel == iss_sel (same-cycle writeback frees the register).
- iss_ready is forced high while flush=1.
- rsN_busy = busy[rsN_sel] & ~(wr_en & wr_sel == rsN_sel). This is a writeback bypass, so the consumer sees the register as free in the writeback cycle.
- wr_err: set on the next edge when wr_en=1 and busy[wr_sel]=0, unless flush=1 that cycle. It is cleared only by rst.
- busy_cnt always equals popcount(busy). It is maintained incrementally (+1 set, −1 clear, 0 for set and clear on the same register) and reset to 0 on flush.

## Timing
- rst: wr_onehot=0, wr_valid=0, busy=0, busy_cnt=0, wr_err=0 on the first edge with rst=1. Inputs are ignored during that edge.
- Reset in the middle of operation discards all pending state with no drain.
- Write decode latency: 1 cycle (wr_en at edge n produces wr_onehot at edge n+1).
- Busy latency: set and clear are visible on busy, rsN_busy and iss_ready from the next cycle.
- busy_cnt saturation cannot occur: NREG set bits need at most ADDR_W+1 bits.
- Boundaries: address NREG−1 decodes to the MSB. Back-to-back issue/writeback pairs to the same register sustain one per cycle.

## Configuration
- REGDEC_X0_HARDWIRED_EN defined:
  - Register 0 is never set busy. iss_ready is always high for iss_sel=0, and rsN_busy is always 0 for rsN_sel=0.
  - Writeback to 0 produces wr_onehot=0 and wr_valid=0, and never sets wr_err.
- Undefined: register 0 behaves like every other register.

## Structure
- Package regdec_pkg holds:
  - ADDR_W default
  - a function returning NREG from ADDR_W
  - a zero-register index constant
- Sub-module decoder_onehot: a parametrised combinational N-to-2^N decoder with enable.
  - Instantiated for writeback decode (registered in the parent).
  - Instantiated for issue set-mask generation.

## Test plan
- Reset: drive wr_en=1, wr_sel=3 together with rst=1. Next cycle wr_onehot=0, busy=0, busy_cnt=0, wr_err=0.
- Decode sweep, ADDR_W=5: wr_sel 0..31, one per cycle. Each wr_onehot = 1<<sel one cycle later. With the macro, sel 0 gives 0 and wr_valid=0.
- Hazard: issue sel=7. The following cycle rs1_sel=7 gives rs1_busy=1, and iss_sel=7 gives iss_ready=0. Writeback 7: rs1_busy=0 in that same cycle, busy[7]=0 and busy_cnt=0 the next cycle.
- Simultaneous set and clear: busy[5]=1, then issue 5 with writeback 5 in the same cycle. busy[5] stays 1 and busy_cnt is unchanged.
- Flush: busy = {2,9,31}, then flush=1 with iss_en=1, iss_sel=4. Next cycle busy=0 and busy_cnt=0.
- Error: writeback to sel=12 while busy[12]=0 sets wr_err=1. It stays 1 through later traffic until rst.
